// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcode and load-funct3 encodings, writeback FSM states,
// and the writing-opcode decode.
package cpu_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_t;

  function automatic logic is_writing(input logic [4:0] opcode);
    case (opcode)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Upstream instruction handshake, data-memory read response and register-file write port
// of the writeback stage.
interface writeback_stage_if;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  modport master (
    output valid_i, opcode_i, funct3_i, rd_i, alu_result_i, mem_rvalid_i, mem_rdata_i,
    input  ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  valid_i, opcode_i, funct3_i, rd_i, alu_result_i, mem_rvalid_i, mem_rdata_i,
    output ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/half/word from a word-aligned memory read
// and flags misaligned or illegal load encodings.
module load_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU: data = {24'h0, byte_lane};
      F3_LH: begin
        data       = {{16{half_lane[15]}}, half_lane};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {16'h0, half_lane};
        misaligned = addr[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires instructions into the register file and counts them.
// Define WB_LOAD_TIMEOUT_EN to abandon loads whose response never arrives.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int INSTRET_W = 32
`ifdef WB_LOAD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_stage_if.slave     bus,
  output logic                 load_err_o,
  output logic [INSTRET_W-1:0] instret_o
`ifdef WB_LOAD_TIMEOUT_EN
  , output logic               timeout_o
`endif
);

  wb_state_t   state;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_misaligned;
  logic        ld_illegal;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt;
`endif

  load_align u_load_align (
    .funct3     (ld_funct3),
    .addr       (ld_addr),
    .word       (bus.mem_rdata_i),
    .data       (ld_data),
    .misaligned (ld_misaligned),
    .illegal    (ld_illegal)
  );

  assign bus.ready_o = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.rf_we_o    <= 1'b0;
      bus.rf_waddr_o <= '0;
      bus.rf_wdata_o <= '0;
      load_err_o     <= 1'b0;
      instret_o      <= '0;
      ld_rd          <= '0;
      ld_funct3      <= '0;
      ld_addr        <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
      timeout_o      <= 1'b0;
      wait_cnt       <= '0;
`endif
    end else begin
      bus.rf_we_o <= 1'b0;
      load_err_o  <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      timeout_o   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            if (bus.opcode_i == OP_LOAD) begin
              ld_rd     <= bus.rd_i;
              ld_funct3 <= bus.funct3_i;
              ld_addr   <= bus.alu_result_i[1:0];
              state     <= WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              instret_o <= instret_o + INSTRET_W'(1);
              if (is_writing(bus.opcode_i)) begin
                bus.rf_we_o    <= (bus.rd_i != 5'd0);
                bus.rf_waddr_o <= bus.rd_i;
                bus.rf_wdata_o <= bus.alu_result_i;
              end
            end
          end
        end
        WAIT_LOAD: begin
          if (bus.mem_rvalid_i) begin
            state     <= IDLE;
            instret_o <= instret_o + INSTRET_W'(1);
            if (ld_misaligned || ld_illegal) begin
              load_err_o <= 1'b1;
            end else begin
              bus.rf_we_o    <= (ld_rd != 5'd0);
              bus.rf_waddr_o <= ld_rd;
              bus.rf_wdata_o <= ld_data;
            end
          end
`ifdef WB_LOAD_TIMEOUT_EN
          // The load is abandoned without retiring; its late response lands in IDLE and is dropped.
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; a 4-bit instret exercises counter wrap.
module tb_writeback_stage;
  import cpu_pkg::*;

  localparam int IW = 4;

  logic          clk;
  logic          rst;
  logic          load_err;
  logic [IW-1:0] instret;
`ifdef WB_LOAD_TIMEOUT_EN
  logic          timeout;
`endif

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [IW-1:0] exp_instret = '0;

  writeback_stage_if bus ();

  writeback_stage #(
    .INSTRET_W      (IW)
`ifdef WB_LOAD_TIMEOUT_EN
    , .TIMEOUT_CYCLES (4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .load_err_o (load_err),
    .instret_o  (instret)
`ifdef WB_LOAD_TIMEOUT_EN
    , .timeout_o  (timeout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu);
    bus.valid_i      = 1'b1;
    bus.opcode_i     = op;
    bus.funct3_i     = f3;
    bus.rd_i         = rd;
    bus.alu_result_i = alu;
    step();
    bus.valid_i      = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rdata;
    step();
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, " we"},    32'(bus.rf_we_o),    32'(1));
    check({tag, " waddr"}, 32'(bus.rf_waddr_o), 32'(rd));
    check({tag, " wdata"}, bus.rf_wdata_o,      data);
    check({tag, " instret"}, 32'(instret),      32'(exp_instret));
  endtask

  task automatic check_nowrite(input string tag, input logic err);
    check({tag, " we"},      32'(bus.rf_we_o), 32'(0));
    check({tag, " err"},     32'(load_err),    32'(err));
    check({tag, " instret"}, 32'(instret),     32'(exp_instret));
  endtask

  initial begin
    rst              = 1'b1;
    bus.valid_i      = 1'b0;
    bus.opcode_i     = '0;
    bus.funct3_i     = '0;
    bus.rd_i         = '0;
    bus.alu_result_i = '0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    step();
    step();
    check("rst we",      32'(bus.rf_we_o),    32'(0));
    check("rst waddr",   32'(bus.rf_waddr_o), 32'(0));
    check("rst wdata",   bus.rf_wdata_o,      32'h0);
    check("rst err",     32'(load_err),       32'(0));
    check("rst instret", 32'(instret),        32'(0));
    check("rst ready",   32'(bus.ready_o),    32'(1));
    rst = 1'b0;
    step();

    // OP-IMM retires next cycle, then the strobe drops
    issue(OP_IMM, 3'b000, 5'd5, 32'h0000_002A);
    exp_instret++;
    check_write("opimm", 5'd5, 32'h0000_002A);
    step();
    check("opimm we drop", 32'(bus.rf_we_o), 32'(0));

    // LB from byte lane 3, response two cycles after accept
    issue(OP_LOAD, F3_LB, 5'd3, 32'h0000_1003);
    check("lb ready wait0", 32'(bus.ready_o), 32'(0));
    step();
    check("lb ready wait1", 32'(bus.ready_o), 32'(0));
    respond(32'h80FF_1234);
    exp_instret++;
    check_write("lb", 5'd3, 32'hFFFF_FF80);
    check("lb ready back", 32'(bus.ready_o), 32'(1));

    issue(OP_LOAD, F3_LHU, 5'd7, 32'h0000_1002);
    respond(32'hBEEF_0000);
    exp_instret++;
    check_write("lhu", 5'd7, 32'h0000_BEEF);

    issue(OP_LOAD, F3_LW, 5'd8, 32'h0000_1001);
    respond(32'h1122_3344);
    exp_instret++;
    check_nowrite("lw misaligned", 1'b1);
    step();
    check("lw err drop", 32'(load_err), 32'(0));

    issue(OP_LOAD, 3'b011, 5'd9, 32'h0000_1000);
    respond(32'h1122_3344);
    exp_instret++;
    check_nowrite("illegal f3", 1'b1);

    issue(OP_LOAD, F3_LBU, 5'd10, 32'h0000_2001);
    respond(32'h0000_9A00);
    exp_instret++;
    check_write("lbu lane1", 5'd10, 32'h0000_009A);

    issue(OP_LOAD, F3_LH, 5'd11, 32'h0000_2002);
    respond(32'h8001_0000);
    exp_instret++;
    check_write("lh upper", 5'd11, 32'hFFFF_8001);

    issue(OP_LOAD, F3_LH, 5'd12, 32'h0000_2001);
    respond(32'h8001_0000);
    exp_instret++;
    check_nowrite("lh misaligned", 1'b1);

    issue(OP_OP, 3'b000, 5'd0, 32'h0000_1234);
    exp_instret++;
    check_nowrite("op rd0", 1'b0);

    issue(OP_STORE, 3'b010, 5'd4, 32'h0000_3000);
    exp_instret++;
    check_nowrite("store", 1'b0);

    // Back-to-back non-loads retire one per cycle
    bus.valid_i      = 1'b1;
    bus.opcode_i     = OP_OP;
    bus.rd_i         = 5'd1;
    bus.alu_result_i = 32'h11;
    step();
    exp_instret++;
    check_write("b2b op", 5'd1, 32'h11);
    bus.opcode_i     = OP_JAL;
    bus.rd_i         = 5'd2;
    bus.alu_result_i = 32'h22;
    step();
    bus.valid_i      = 1'b0;
    exp_instret++;
    check_write("b2b jal", 5'd2, 32'h22);

    // Six more retirements carry the 4-bit counter through all-ones to zero
    for (int i = 0; i < 6; i++) begin
      issue(OP_BRANCH, 3'b000, 5'd6, 32'h0);
      exp_instret++;
      check("wrap instret", 32'(instret), 32'(exp_instret));
    end
    check("wrap value", 32'(instret), 32'(2));

    // Stray response in IDLE changes nothing
    respond(32'hDEAD_BEEF);
    check_nowrite("stray rvalid", 1'b0);
    check("stray waddr", 32'(bus.rf_waddr_o), 32'(2));
    check("stray wdata", bus.rf_wdata_o,      32'h22);

    // Response in the accept cycle is ignored; then reset discards the pending load
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_5555;
    issue(OP_LOAD, F3_LW, 5'd13, 32'h0000_4000);
    bus.mem_rvalid_i = 1'b0;
    check("accept rvalid ignored", 32'(bus.ready_o), 32'(0));
    check("accept rvalid no we",   32'(bus.rf_we_o), 32'(0));
    #2;
    rst = 1'b1;
    #1;
    exp_instret = '0;
    check("async rst instret", 32'(instret),        32'(0));
    check("async rst ready",   32'(bus.ready_o),    32'(1));
    check("async rst wdata",   bus.rf_wdata_o,      32'h0);
    step();
    rst = 1'b0;
    respond(32'h7777_7777);
    check_nowrite("post rst rvalid", 1'b0);
    check("post rst waddr", 32'(bus.rf_waddr_o), 32'(0));

`ifdef WB_LOAD_TIMEOUT_EN
    issue(OP_LOAD, F3_LW, 5'd14, 32'h0000_5000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("timeout early", 32'(timeout), 32'(0));
    end
    step();
    check("timeout pulse", 32'(timeout),     32'(1));
    check("timeout ready", 32'(bus.ready_o), 32'(1));
    check_nowrite("timeout", 1'b0);
    step();
    check("timeout drop", 32'(timeout), 32'(0));
    respond(32'h9999_9999);
    check_nowrite("late rvalid", 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
